eq_encoder: RTL and testbench

Encoder companion to the 2-bit → one-hot `eq` decoder: accepts 4-bit one-hot request words (`eq3..eq0` order), converts each set bit back to its 2-bit index, and delivers the indices over a valid/ready output handshake. Non-one-hot words are flagged and counted, and every set bit is still drained in ascending index order. It sits downstream of the decode stage and closes the loop for round-trip checking of `A_in`/`B_in` selections.

---
 rtl/eq_encoder.sv | 96 +++++++++
 tb/tb_eq_encoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/eq_encoder.sv
// eq_encoder: turns 4-bit request words back into 2-bit indices, draining every set bit lowest-first
// over a valid/ready port; non-one-hot words raise a one-cycle flag and bump a saturating counter.
module eq_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [3:0]           Eq_in,
    input  logic                 Eq_valid_in,
    output logic                 Eq_ready_out,
    output logic [1:0]           Code_out,
    output logic                 Code_valid_out,
    input  logic                 Code_ready_in,
    output logic                 Code_par_out,
    output logic                 Onehot_err_out,
    output logic [ERR_CNT_W-1:0] Err_cnt_out
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_pending;
    logic [3:0]           w_pending_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
    logic [1:0]           w_code;
    logic [3:0]           w_code_mask;
    logic                 w_onehot;

    // Lowest set bit wins; an empty mask encodes to 0 so IDLE/reset shows Code_out = 0.
    always_comb begin
        w_code = 2'd0;
        if (r_pending[0])      w_code = 2'd0;
        else if (r_pending[1]) w_code = 2'd1;
        else if (r_pending[2]) w_code = 2'd2;
        else if (r_pending[3]) w_code = 2'd3;
    end

    assign w_code_mask = 4'b0001 << w_code;
    assign w_onehot    = (Eq_in != 4'd0) && ((Eq_in & (Eq_in - 4'd1)) == 4'd0);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_pending <= 4'd0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (Eq_valid_in) begin
                    w_pending_nxt = Eq_in;
                    if (Eq_in != 4'd0) w_state_nxt = S_DRAIN;
                    if (!w_onehot) begin
                        w_err_nxt = 1'b1;
                        if (r_err_cnt != CNT_MAX) w_err_cnt_nxt = r_err_cnt + CNT_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (Code_ready_in) begin
                    w_pending_nxt = r_pending & ~w_code_mask;
                    if (w_pending_nxt == 4'd0) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign Eq_ready_out   = (r_state == S_IDLE);
    assign Code_valid_out = (r_state == S_DRAIN);
    assign Code_out       = w_code;
    assign Code_par_out   = w_code[1] ^ w_code[0];
    assign Onehot_err_out = r_err;
    assign Err_cnt_out    = r_err_cnt;
endmodule

// File: tb/tb_eq_encoder.sv
// Bench for eq_encoder: a queue-of-indices model checked every cycle, plus directed
// vectors with literal expectations (ERR_CNT_W = 2 so saturation is reachable).
module tb_eq_encoder;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          Clock = 1'b0;
    logic          Reset_n = 1'b0;
    logic [3:0]    Eq_in = 4'd0;
    logic          Eq_valid_in = 1'b0;
    logic          Eq_ready_out;
    logic [1:0]    Code_out;
    logic          Code_valid_out;
    logic          Code_ready_in = 1'b1;
    logic          Code_par_out;
    logic          Onehot_err_out;
    logic [CW-1:0] Err_cnt_out;

    int n_tests = 0;
    int n_fail  = 0;

    eq_encoder #(.ERR_CNT_W(CW)) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .Eq_in          (Eq_in),
        .Eq_valid_in    (Eq_valid_in),
        .Eq_ready_out   (Eq_ready_out),
        .Code_out       (Code_out),
        .Code_valid_out (Code_valid_out),
        .Code_ready_in  (Code_ready_in),
        .Code_par_out   (Code_par_out),
        .Onehot_err_out (Onehot_err_out),
        .Err_cnt_out    (Err_cnt_out)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the indices still owed downstream, oldest first.
    int m_q[$];
    int m_cnt = 0;
    bit m_err = 1'b0;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_q.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_q.size() != 0) begin
                if (Code_ready_in) void'(m_q.pop_front());
            end else if (Eq_valid_in) begin
                if ($countones(Eq_in) != 1) begin
                    m_err = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
                for (int i = 0; i < 4; i++)
                    if (Eq_in[i]) m_q.push_back(i);
            end
        end
    end

    always @(negedge Clock) begin
        int ec;
        ec = (m_q.size() != 0) ? m_q[0] : 0;
        check("m_ready", {31'd0, Eq_ready_out}, (m_q.size() == 0) ? 1 : 0);
        check("m_valid", {31'd0, Code_valid_out}, (m_q.size() != 0) ? 1 : 0);
        check("m_code", {30'd0, Code_out}, ec);
        check("m_par", {31'd0, Code_par_out}, ec[1] ^ ec[0]);
        check("m_err", {31'd0, Onehot_err_out}, {31'd0, m_err});
        check("m_cnt", {30'd0, Err_cnt_out}, m_cnt);
    end

    task automatic tick();
        @(negedge Clock);
    endtask

    int exp_par[4] = '{0, 1, 1, 0};
    int exp_sat[5] = '{1, 2, 3, 3, 3};

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            tick();
            Eq_in         = 4'($urandom_range(0, 15));
            Eq_valid_in   = 1'($urandom_range(0, 1));
            Code_ready_in = 1'($urandom_range(0, 1));
            #1;
            check("rst_valid", {31'd0, Code_valid_out}, 0);
            check("rst_cnt", {30'd0, Err_cnt_out}, 0);
            check("rst_err", {31'd0, Onehot_err_out}, 0);
            check("rst_ready", {31'd0, Eq_ready_out}, 1);
        end
        tick();
        Reset_n = 1'b1; Eq_valid_in = 1'b0; Eq_in = 4'd0; Code_ready_in = 1'b1;

        // Single one-hot words
        for (int i = 0; i < 4; i++) begin
            tick();
            Eq_in = 4'b0001 << i; Eq_valid_in = 1'b1;
            tick();
            Eq_valid_in = 1'b0;
            check("oh_valid", {31'd0, Code_valid_out}, 1);
            check("oh_code", {30'd0, Code_out}, i);
            check("oh_par", {31'd0, Code_par_out}, exp_par[i]);
            check("oh_err", {31'd0, Onehot_err_out}, 0);
            tick();
            check("oh_ready", {31'd0, Eq_ready_out}, 1);
        end

        // Multi-bit word 1011
        tick();
        Eq_in = 4'b1011; Eq_valid_in = 1'b1;
        tick();
        Eq_valid_in = 1'b0;
        check("mb_err", {31'd0, Onehot_err_out}, 1);
        check("mb_cnt", {30'd0, Err_cnt_out}, 1);
        check("mb_code0", {30'd0, Code_out}, 0);
        tick();
        check("mb_err_clr", {31'd0, Onehot_err_out}, 0);
        check("mb_code1", {30'd0, Code_out}, 1);
        tick();
        check("mb_code3", {30'd0, Code_out}, 3);
        tick();
        check("mb_ready", {31'd0, Eq_ready_out}, 1);
        check("mb_valid", {31'd0, Code_valid_out}, 0);

        // Backpressure on 0110, with another word pushed meanwhile
        tick();
        Eq_in = 4'b0110; Eq_valid_in = 1'b1; Code_ready_in = 1'b0;
        tick();
        Eq_in = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, Code_valid_out}, 1);
            check("bp_code", {30'd0, Code_out}, 1);
            check("bp_ready", {31'd0, Eq_ready_out}, 0);
            if (i < 4) tick();
        end
        Code_ready_in = 1'b1; Eq_valid_in = 1'b0;
        tick();
        check("bp_code2", {30'd0, Code_out}, 2);
        check("bp_cnt", {30'd0, Err_cnt_out}, 2);
        tick();
        check("bp_ready_end", {31'd0, Eq_ready_out}, 1);

        // Zero words and saturation, from a fresh reset
        tick();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        Eq_in = 4'd0; Eq_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("z_err", {31'd0, Onehot_err_out}, 1);
            check("z_cnt", {30'd0, Err_cnt_out}, exp_sat[i]);
            check("z_valid", {31'd0, Code_valid_out}, 0);
        end
        Eq_valid_in = 1'b0;
        tick();
        check("z_err_end", {31'd0, Onehot_err_out}, 0);

        // Reset in the middle of draining 1111
        Eq_in = 4'b1111; Eq_valid_in = 1'b1;
        tick();
        Eq_valid_in = 1'b0;
        check("rm_code0", {30'd0, Code_out}, 0);
        tick();
        check("rm_code1", {30'd0, Code_out}, 1);
        @(posedge Clock);
        #3 Reset_n = 1'b0;
        #1;
        check("rm_valid", {31'd0, Code_valid_out}, 0);
        check("rm_code", {30'd0, Code_out}, 0);
        check("rm_par", {31'd0, Code_par_out}, 0);
        check("rm_ready", {31'd0, Eq_ready_out}, 1);
        check("rm_cnt", {30'd0, Err_cnt_out}, 0);
        tick();
        tick();
        Reset_n = 1'b1; Eq_in = 4'b0100; Eq_valid_in = 1'b1;
        tick();
        Eq_valid_in = 1'b0;
        check("rm_code2", {30'd0, Code_out}, 2);
        check("rm_valid2", {31'd0, Code_valid_out}, 1);
        tick();
        check("rm_done", {31'd0, Code_valid_out}, 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
